// File: rtl/fib_seq_gen.sv
// Fibonacci/Lucas term engine: walks T0..Tn one term per advance, optionally
// streaming each term with backpressure, and latches Tn plus a sticky wrap flag.

module fib_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_a_ovf,
  input  logic             i_b_ovf,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_sum_ovf
);
  logic w_carry;

  assign {w_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};
  // Wrap history propagates forward: any wrapped ancestor taints the new term.
  assign o_sum_ovf = i_a_ovf | i_b_ovf | w_carry;
endmodule

module fib_seq_gen #(
  parameter int WIDTH     = 16,
  parameter int IDX_W     = 6,
  parameter int STREAM_EN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [IDX_W-1:0] n,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             overflow,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam bit STREAM = (STREAM_EN != 0);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_a_ovf, r_b_ovf;
  logic [IDX_W-1:0] r_cnt, r_n_q;
  logic             r_mode_q;
  logic [WIDTH-1:0] r_dout;
  logic             r_ovf;
  logic             r_done;

  logic             w_adv, w_last;
  logic             w_load, w_step, w_fin;
  logic [WIDTH-1:0] w_seed0, w_sum;
  logic             w_sum_ovf;

  assign w_adv   = !STREAM || out_ready;
  assign w_last  = (r_cnt == r_n_q);
  assign w_seed0 = mode ? WIDTH'(2) : '0;

  fib_step #(.WIDTH(WIDTH)) u_step (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_a_ovf   (r_a_ovf),
    .i_b_ovf   (r_b_ovf),
    .o_sum     (w_sum),
    .o_sum_ovf (w_sum_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_adv) begin
          if (w_last) begin
            w_fin       = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_step = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_a_ovf  <= 1'b0;
      r_b_ovf  <= 1'b0;
      r_cnt    <= '0;
      r_n_q    <= '0;
      r_mode_q <= 1'b0;
    end else if (w_load) begin
      r_a      <= w_seed0;
      r_b      <= WIDTH'(1);
      r_a_ovf  <= 1'b0;
      r_b_ovf  <= 1'b0;
      r_cnt    <= '0;
      r_n_q    <= n;
      r_mode_q <= mode;
    end else if (w_step) begin
      r_a     <= r_b;
      r_b     <= w_sum;
      r_a_ovf <= r_b_ovf;
      r_b_ovf <= w_sum_ovf;
      r_cnt   <= r_cnt + IDX_W'(1);
    end
  end

  // Result regs hold between completions; only the lookahead-free a_ovf is reported.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= '0;
      r_ovf  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_fin) begin
        r_dout <= r_a;
        r_ovf  <= r_a_ovf;
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign dout      = r_dout;
  assign overflow  = r_ovf;
  assign out_valid = STREAM && (r_state == S_RUN);
  assign out_data  = r_a;
  assign out_last  = out_valid && w_last;
endmodule

// File: tb/tb_fib_seq_gen.sv
// Scoreboard bench for fib_seq_gen: a wide-integer model queues expected stream
// terms and results at start; monitors pop and compare on the falling edge.

module tb_fib_seq_gen;
  localparam int WIDTH = 16;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [IDX_W-1:0] n;
  logic             mode;
  logic             busy, done, overflow, out_valid, out_last, out_ready;
  logic [WIDTH-1:0] dout, out_data;

  typedef struct {logic [WIDTH-1:0] d; bit last;} s_exp_t;
  typedef struct {logic [WIDTH-1:0] d; bit ovf; int cyc;} r_exp_t;

  s_exp_t s_q[$];
  r_exp_t r_q[$];
  int errs = 0, checks = 0, cyc = 0;
  logic [WIDTH-1:0] last_d;
  bit last_ovf;

  fib_seq_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W), .STREAM_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .n(n), .mode(mode),
    .busy(busy), .done(done), .dout(dout), .overflow(overflow),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Exact-precision model: a term has wrapped once its true value reaches 2^WIDTH.
  task automatic push_expect(input int nn, input bit md, input int done_cyc);
    longint t0, t1, nx;
    bit ovf;
    r_exp_t r;
    t0 = md ? 2 : 0;
    t1 = 1;
    ovf = 0;
    for (int k = 0; k <= nn; k++) begin
      if (t0 >= (longint'(1) << WIDTH)) ovf = 1;
      s_q.push_back('{d: WIDTH'(t0), last: (k == nn)});
      if (k == nn) begin
        r.d = WIDTH'(t0);
        r.ovf = ovf;
      end
      nx = t0 + t1;
      t0 = t1;
      t1 = nx;
    end
    r.cyc = done_cyc;
    r_q.push_back(r);
    last_d = r.d;
    last_ovf = r.ovf;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (out_valid) begin
        if (s_q.size() == 0) chk("stream_extra", 1, 0);
        else if (out_ready) begin
          s_exp_t e;
          e = s_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.last);
        end else begin
          chk("stall_hold", out_data, s_q[0].d);
        end
      end
      if (done) begin
        if (r_q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          r_exp_t r;
          r = r_q.pop_front();
          chk("dout", dout, r.d);
          chk("overflow", overflow, r.ovf);
          chk("done_cycle", cyc, r.cyc);
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  task automatic wait_drain(input string tag);
    int guard = 0;
    while (r_q.size() != 0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (r_q.size() != 0) begin
      chk({tag, "_timeout"}, r_q.size(), 0);
      r_q.delete();
      s_q.delete();
    end
  endtask

  task automatic run_req(input int nn, input bit md, input int stall_at,
                         input int stall_len, input bit poke);
    int t0, k, guard;
    @(posedge clk); #1;
    n = IDX_W'(nn);
    mode = md;
    start = 1'b1;
    t0 = cyc + 1;
    push_expect(nn, md, t0 + nn + 1 + stall_len);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    guard = 0;
    while (r_q.size() != 0 && guard < 300) begin
      out_ready = !(k >= stall_at && k < stall_at + stall_len);
      start = poke && (k == 2);
      if (poke && k == 2) n = IDX_W'(1);
      @(posedge clk); #1;
      k++;
      guard++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (r_q.size() != 0) begin
      chk("run_timeout", r_q.size(), 0);
      r_q.delete();
      s_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("dout_hold", dout, last_d);
    chk("ovf_hold", overflow, last_ovf);
  endtask

  initial begin
    int t0;
    reset_n = 1'b0;
    start = 1'b0;
    n = '0;
    mode = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    reset_n = 1'b1;

    run_req(10, 0, -1, 0, 0);   // 0,1,1,...,55
    run_req(5, 1, -1, 0, 0);    // Lucas 2,1,3,4,7,11
    run_req(0, 0, -1, 0, 0);
    run_req(0, 1, -1, 0, 0);
    run_req(24, 0, -1, 0, 0);   // 46368, no wrap
    run_req(25, 0, -1, 0, 0);   // 9489, wrapped
    run_req(30, 1, -1, 0, 0);
    run_req(63, 0, -1, 0, 0);
    run_req(6, 0, 3, 3, 1);     // stall on term 3, start poked mid-run

    // Back-to-back n=0: start held through RUN, re-accepted in the done cycle.
    @(posedge clk); #1;
    n = '0;
    mode = 1'b0;
    start = 1'b1;
    t0 = cyc + 1;
    push_expect(0, 0, t0 + 1);
    push_expect(0, 1, t0 + 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("b2b");

    // Reset while cnt==7 of an n=20 run.
    @(posedge clk); #1;
    n = IDX_W'(20);
    mode = 1'b0;
    start = 1'b1;
    push_expect(20, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dout", dout, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_valid", out_valid, 0);
    r_q.delete();
    s_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_abort_busy", busy, 0);
    run_req(3, 0, -1, 0, 0);

    chk("stream_drained", s_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
